// File: rtl/ipg_slot_inserter_pkg.sv
// Shared XGMII constants and the idle-block detector for the IPG slot inserter.
package ipg_pkg;

    localparam logic [7:0]  XGMII_IDLE_CHAR  = 8'h07;
    localparam logic [63:0] XGMII_IDLE_BLOCK = {8{XGMII_IDLE_CHAR}};
    localparam logic [7:0]  XGMII_IDLE_CTRL  = 8'hFF;
    localparam logic [7:0]  DEFAULT_MSG_CTRL = 8'h5C;

    // A block is idle only when every lane is a control lane carrying /I/.
    function automatic logic is_idle_block(input logic [63:0] txd, input logic [7:0] txc);
        return (txc == XGMII_IDLE_CTRL) && (txd == XGMII_IDLE_BLOCK);
    endfunction

endpackage

// File: rtl/ipg_slot_inserter_if.sv
// MAC/PHY/message-channel bundle for the IPG slot inserter.
// Optional stats outputs exist only when IPG_SLOT_STATS_EN is defined.
interface ipg_slot_inserter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int N_CH       = 4,
    parameter int MSG_WIDTH  = DATA_WIDTH - 8
);
    logic [DATA_WIDTH-1:0]     mac_txd;
    logic [CTRL_WIDTH-1:0]     mac_txc;
    logic                      tx_pause;
    logic [N_CH-1:0]           msg_valid;
    logic [N_CH*MSG_WIDTH-1:0] msg_data;
    logic [N_CH-1:0]           msg_ready;
    logic [DATA_WIDTH-1:0]     phy_txd;
    logic [CTRL_WIDTH-1:0]     phy_txc;
    logic                      insert_active;
`ifdef IPG_SLOT_STATS_EN
    logic [31:0]               stat_insert_cnt;
    logic [31:0]               stat_pause_cnt;
`endif

    // Inserter side.
    modport slave (
        input  mac_txd, mac_txc, msg_valid, msg_data,
        output tx_pause, msg_ready, phy_txd, phy_txc, insert_active
`ifdef IPG_SLOT_STATS_EN
        , output stat_insert_cnt, stat_pause_cnt
`endif
    );

    // MAC, channels and PHY side.
    modport master (
        output mac_txd, mac_txc, msg_valid, msg_data,
        input  tx_pause, msg_ready, phy_txd, phy_txc, insert_active
`ifdef IPG_SLOT_STATS_EN
        , input stat_insert_cnt, stat_pause_cnt
`endif
    );
endinterface

// File: rtl/ipg_slot_inserter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module ipg_rr_arbiter #(
    parameter  int N_CH  = 4,
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic             en,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);
    logic found;

    // Scan channels starting at ptr, wrapping modulo N_CH.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N_CH) j = j - N_CH;
            if (en && !found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/ipg_slot_inserter.sv
// Steals idle XGMII blocks (never the first after a frame) to carry
// side-band channel messages; asserts tx_pause when a channel starves.
// Optional statistics counters: define IPG_SLOT_STATS_EN.
module ipg_slot_inserter
    import ipg_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int         N_CH       = 4,
    parameter int         MSG_WIDTH  = DATA_WIDTH - 8,
    parameter logic [7:0] MSG_CTRL   = DEFAULT_MSG_CTRL,
    parameter int         MAX_WAIT   = 64
) (
    input  logic              tx_clk,
    input  logic              tx_rst,
    ipg_slot_inserter_if.slave bus
);
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic                  prev_idle;
    logic [IDX_W-1:0]      rr_ptr;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     wait_nxt;
    logic                  idle_now;
    logic                  slot_ok;
    logic [N_CH-1:0]       grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  granted;
    logic [MSG_WIDTH-1:0]  msg_sel;
    logic [DATA_WIDTH-1:0] txd_q;
    logic [CTRL_WIDTH-1:0] txc_q;
    logic                  ins_q;
    logic                  pause_q;

    assign idle_now = is_idle_block(bus.mac_txd, bus.mac_txc);
    // Held off during reset so a request seen in a reset cycle stays pending.
    assign slot_ok  = idle_now && prev_idle && !tx_rst;

    ipg_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req       (bus.msg_valid),
        .en        (slot_ok),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign granted = |grant;
    assign msg_sel = bus.msg_data[int'(grant_idx)*MSG_WIDTH +: MSG_WIDTH];

    // Starvation count: runs while someone waits unserved, saturating.
    always_comb begin
        wait_nxt = wait_cnt;
        if (granted || !(|bus.msg_valid)) wait_nxt = '0;
        else if (wait_cnt < WAIT_MAX)     wait_nxt = wait_cnt + 1'b1;
    end

    // Output block, arbitration pointer, idle history and pause request.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            txd_q     <= XGMII_IDLE_BLOCK;
            txc_q     <= XGMII_IDLE_CTRL;
            ins_q     <= 1'b0;
            pause_q   <= 1'b0;
            rr_ptr    <= '0;
            wait_cnt  <= '0;
            prev_idle <= 1'b0;
        end else begin
            prev_idle <= idle_now;
            wait_cnt  <= wait_nxt;
            pause_q   <= (wait_nxt >= WAIT_MAX);
            if (granted) begin
                txd_q  <= {msg_sel, MSG_CTRL};
                txc_q  <= CTRL_WIDTH'(1);
                ins_q  <= 1'b1;
                rr_ptr <= (grant_idx == IDX_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                txd_q  <= bus.mac_txd;
                txc_q  <= bus.mac_txc;
                ins_q  <= 1'b0;
            end
        end
    end

    assign bus.msg_ready     = grant;
    assign bus.phy_txd       = txd_q;
    assign bus.phy_txc       = txc_q;
    assign bus.insert_active = ins_q;
    assign bus.tx_pause      = pause_q;

`ifdef IPG_SLOT_STATS_EN
    logic [31:0] ins_cnt;
    logic [31:0] pse_cnt;

    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            ins_cnt <= '0;
            pse_cnt <= '0;
        end else begin
            if (granted) ins_cnt <= ins_cnt + 1'b1;
            if (pause_q) pse_cnt <= pse_cnt + 1'b1;
        end
    end

    assign bus.stat_insert_cnt = ins_cnt;
    assign bus.stat_pause_cnt  = pse_cnt;
`endif
endmodule
